uart_mmio: RTL

UART_MMIO -- requirements
Module: uart_mmio

---
 rtl/uart_mmio.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with TXD/RXD/CON registers for a MIPS-style MEM stage
module uart_mmio #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic [31:0] EX_ALUOut,
    input  logic [31:0] EX_WrData,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic [31:0] UARTReadOut,
    output logic        UARTHit
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] TXD_A = 32'h4000_0018;
    localparam logic [31:0] RXD_A = 32'h4000_001C;
    localparam logic [31:0] CON_A = 32'h4000_0020;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]    tx_byte_q, tx_byte_d, rx_data_q, rx_data_d, rx_sh_q, rx_sh_d;
    logic          tx_q, tx_d, tx_done_q, tx_done_d;
    logic          rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, ferr_q, ferr_d;
    logic          s1_q, s2_q;
    logic          hit_tx, hit_rx, hit_con, tx_busy, tx_wr, rx_rd, con_wr;
    logic          tx_last, rx_ok, rx_bad, unused_ok;

    assign hit_tx      = EX_ALUOut == TXD_A;
    assign hit_rx      = EX_ALUOut == RXD_A;
    assign hit_con     = EX_ALUOut == CON_A;
    assign UARTHit     = hit_tx | hit_rx | hit_con;
    assign tx_busy     = tx_st_q != IDLE;
    assign tx_wr       = EX_MemWrite & hit_tx & ~tx_busy;
    assign rx_rd       = EX_MemRead & hit_rx;
    assign con_wr      = EX_MemWrite & hit_con;
    assign UART_TX     = tx_q;
    assign unused_ok   = ^EX_WrData[31:8];
    assign UARTReadOut = hit_tx  ? {24'b0, tx_byte_q} :
                         hit_rx  ? {24'b0, rx_data_q} :
                         hit_con ? {27'b0, ferr_q, tx_done_q, rx_ovr_q, rx_valid_q, tx_busy} : 32'b0;

    always_comb begin
        tx_st_d   = tx_st_q;
        tx_cnt_d  = tx_cnt_q + 1'b1;
        tx_bit_d  = tx_bit_q;
        tx_byte_d = tx_byte_q;
        tx_d      = tx_q;
        tx_last   = 1'b0;
        unique case (tx_st_q)
            IDLE: begin
                tx_cnt_d = '0;
                if (tx_wr) begin
                    tx_st_d   = START;
                    tx_byte_d = EX_WrData[7:0];
                    tx_d      = 1'b0;
                end
            end
            START: if (tx_cnt_q == LAST) begin
                tx_st_d  = DATA;
                tx_cnt_d = '0;
                tx_bit_d = '0;
                tx_d     = tx_byte_q[0];
            end
            DATA: if (tx_cnt_q == LAST) begin
                tx_cnt_d = '0;
                tx_bit_d = tx_bit_q + 3'd1;
                tx_st_d  = (tx_bit_q == 3'd7) ? STOP : DATA;
                tx_d     = (tx_bit_q == 3'd7) ? 1'b1 : tx_byte_q[tx_bit_d];
            end
            STOP: if (tx_cnt_q == LAST) begin
                tx_st_d  = IDLE;
                tx_cnt_d = '0;
                tx_last  = 1'b1;
            end
        endcase
    end

    // START only waits half a bit so every later sample lands mid-bit
    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q + 1'b1;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_ok    = 1'b0;
        rx_bad   = 1'b0;
        unique case (rx_st_q)
            IDLE: begin
                rx_cnt_d = '0;
                rx_st_d  = s2_q ? IDLE : START;
            end
            START: if (rx_cnt_q == HALF) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_st_d  = s2_q ? IDLE : DATA;
            end
            DATA: if (rx_cnt_q == LAST) begin
                rx_cnt_d = '0;
                rx_sh_d  = {s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                rx_st_d  = (rx_bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (rx_cnt_q == LAST) begin
                rx_cnt_d = '0;
                rx_st_d  = IDLE;
                rx_ok    = s2_q;
                rx_bad   = ~s2_q;
            end
        endcase
    end

    // hardware set wins over a same-cycle clear
    assign rx_data_d  = rx_ok ? rx_sh_q : rx_data_q;
    assign rx_valid_d = rx_ok | (rx_valid_q & ~rx_rd);
    assign rx_ovr_d   = (rx_ok & rx_valid_q) | (rx_ovr_q & ~(con_wr & EX_WrData[2]));
    assign tx_done_d  = tx_last | (tx_done_q & ~(con_wr & EX_WrData[3]));
    assign ferr_d     = rx_bad | (ferr_q & ~(con_wr & EX_WrData[4]));

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_st_q    <= IDLE;
            rx_st_q    <= IDLE;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            rx_bit_q   <= '0;
            tx_byte_q  <= '0;
            rx_data_q  <= '0;
            rx_sh_q    <= '0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            ferr_q     <= 1'b0;
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
        end else begin
            tx_st_q    <= tx_st_d;
            rx_st_q    <= rx_st_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            rx_bit_q   <= rx_bit_d;
            tx_byte_q  <= tx_byte_d;
            rx_data_q  <= rx_data_d;
            rx_sh_q    <= rx_sh_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            ferr_q     <= ferr_d;
            s1_q       <= UART_RX;
            s2_q       <= s1_q;
        end
    end
endmodule
